// File: rtl/block_to_word.sv
// block_to_word: captures one cache block and returns it as words, critical word first (single or wrapping burst)
// Latency: first word valid the cycle after block accept, then one word per cycle; one idle bubble between transfers
// Backpressure: word outputs held stable while word_ready=0; block_ready is low for the whole transfer
module block_to_word #(
  parameter int ADDRESSIZE    = 32,
  parameter int WORDSIZE      = 32,
  parameter int OFFSETBITS    = 2,
  parameter int BLOCKSIZE     = 16,
  parameter int BLOCKSIZE_log = 4
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic [BLOCKSIZE*WORDSIZE-1:0] block_in,
  input  logic [ADDRESSIZE-1:0]         address,
  input  logic                          burst,
  input  logic                          block_valid,
  output logic                          block_ready,
  output logic [WORDSIZE-1:0]           word_out,
  output logic [BLOCKSIZE_log-1:0]      word_offset,
  output logic                          word_valid,
  input  logic                          word_ready,
  output logic                          word_last,
  output logic                          busy
);

  localparam logic [BLOCKSIZE_log-1:0] LAST_IDX = BLOCKSIZE_log'(BLOCKSIZE - 1);

  typedef enum logic {IDLE = 1'b0, SEND = 1'b1} state_t;

  state_t                              state;
  state_t                              state_nxt;
  logic [BLOCKSIZE-1:0][WORDSIZE-1:0]  buffer;
  logic [BLOCKSIZE_log-1:0]            ptr;
  logic [BLOCKSIZE_log-1:0]            cnt;
  logic [BLOCKSIZE_log-1:0]            start_off;
  logic                                burst_q;
  logic                                last_w;
  logic                                accept;
  logic                                advance;
  logic                                unused_address;

  // Word index of the requested address; only the index bits matter, the rest are deliberately ignored
  assign start_off      = address[BLOCKSIZE_log+OFFSETBITS-1:OFFSETBITS];
  assign unused_address = ^address;

  // Final word: single mode ends after one word, burst after BLOCKSIZE words
  assign last_w  = !burst_q || (cnt == LAST_IDX);
  assign accept  = (state == IDLE) && block_valid;
  assign advance = (state == SEND) && word_ready && !last_w;

  // State register
  always_ff @(posedge clk) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  // Next-state: accept in IDLE, return to IDLE on the final word handshake
  always_comb begin
    state_nxt = state;
    if (state == IDLE) begin
      if (block_valid) state_nxt = SEND;
    end else begin
      if (word_ready && last_w) state_nxt = IDLE;
    end
  end

  // Datapath: capture block on accept, step the wrapping word pointer on each non-final handshake
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      buffer  <= '0;
      ptr     <= '0;
      cnt     <= '0;
      burst_q <= 1'b0;
    end else if (accept) begin
      buffer  <= block_in;
      burst_q <= burst;
      ptr     <= start_off;
      cnt     <= '0;
    end else if (advance) begin
      ptr     <= (ptr == LAST_IDX) ? '0 : ptr + BLOCKSIZE_log'(1);
      cnt     <= cnt + BLOCKSIZE_log'(1);
    end
  end

  // Outputs from registered state only; word fields forced to zero when not valid
  always_comb begin
    block_ready = 1'b1;
    word_valid  = 1'b0;
    word_out    = '0;
    word_offset = '0;
    word_last   = 1'b0;
    busy        = 1'b0;
    if (state == SEND) begin
      block_ready = 1'b0;
      word_valid  = 1'b1;
      word_out    = buffer[ptr];
      word_offset = ptr;
      word_last   = last_w;
      busy        = 1'b1;
    end
  end

endmodule

// File: tb/tb_block_to_word.sv
// tb_block_to_word: table vectors, hand-written corner sequences and a randomized queue-model run
module tb_block_to_word;
  localparam int AW = 32;
  localparam int WW = 32;
  localparam int BS = 16;
  localparam int BL = 4;

  logic              clk = 1'b0;
  logic              rst_n;
  logic [BS*WW-1:0]  block_in;
  logic [AW-1:0]     address;
  logic              burst;
  logic              block_valid;
  logic              block_ready;
  logic [WW-1:0]     word_out;
  logic [BL-1:0]     word_offset;
  logic              word_valid;
  logic              word_ready;
  logic              word_last;
  logic              busy;

  always #5 clk = ~clk;

  block_to_word dut (
    .clk(clk), .rst_n(rst_n), .block_in(block_in), .address(address), .burst(burst),
    .block_valid(block_valid), .block_ready(block_ready), .word_out(word_out),
    .word_offset(word_offset), .word_valid(word_valid), .word_ready(word_ready),
    .word_last(word_last), .busy(busy)
  );

  int n_checks = 0;
  int n_pass   = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  function automatic logic [BS*WW-1:0] make_block(input logic [WW-1:0] base);
    logic [BS*WW-1:0] b;
    for (int i = 0; i < BS; i++) b[i*WW +: WW] = base + WW'(i);
    return b;
  endfunction

  // Outputs are sampled 1 time unit after the rising edge; inputs change at the same point
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic accept(input logic [AW-1:0] a, input logic b, input logic [WW-1:0] base);
    block_in    = make_block(base);
    address     = a;
    burst       = b;
    block_valid = 1'b1;
    tick();
    block_valid = 1'b0;
  endtask

  task automatic drain(input string name);
    int n = 0;
    word_ready = 1'b1;
    while (busy === 1'b1 && n < 40) begin
      tick();
      n++;
    end
    check(name, busy, 0);
  endtask

  typedef struct {
    logic [AW-1:0] addr;
    logic          burst;
    logic [WW-1:0] exp_word;
    logic [BL-1:0] exp_off;
    logic          exp_last;
  } vec_t;

  typedef struct {
    logic [WW-1:0] word;
    logic [BL-1:0] off;
    logic          last;
  } exp_t;

  vec_t vecs[6];
  exp_t q[$];
  exp_t e;
  int   start;
  int   len;
  int   o;

  initial begin
    vecs[0] = '{32'h24, 1'b0, 32'hA000_0009, 4'd9,  1'b1};
    vecs[1] = '{32'h00, 1'b0, 32'hA000_0000, 4'd0,  1'b1};
    vecs[2] = '{32'h3C, 1'b0, 32'hA000_000F, 4'd15, 1'b1};
    vecs[3] = '{32'h27, 1'b0, 32'hA000_0009, 4'd9,  1'b1};
    vecs[4] = '{32'h40, 1'b0, 32'hA000_0000, 4'd0,  1'b1};
    vecs[5] = '{32'h38, 1'b1, 32'hA000_000E, 4'd14, 1'b0};

    rst_n = 1'b0; block_in = '0; address = '0; burst = 1'b0;
    block_valid = 1'b0; word_ready = 1'b1;

    // Reset
    tick(); tick();
    check("rst block_ready", block_ready, 1);
    check("rst word_valid",  word_valid, 0);
    check("rst word_out",    word_out, 0);
    check("rst word_offset", word_offset, 0);
    check("rst busy",        busy, 0);
    rst_n = 1'b1;
    tick();

    // Table: first word of each transfer, then drain and confirm return to IDLE
    for (int v = 0; v < 6; v++) begin
      word_ready = 1'b1;
      accept(vecs[v].addr, vecs[v].burst, 32'hA000_0000);
      check($sformatf("vec%0d word_valid", v), word_valid, 1);
      check($sformatf("vec%0d word_out", v), word_out, vecs[v].exp_word);
      check($sformatf("vec%0d word_offset", v), word_offset, vecs[v].exp_off);
      check($sformatf("vec%0d word_last", v), word_last, vecs[v].exp_last);
      check($sformatf("vec%0d block_ready", v), block_ready, 0);
      drain($sformatf("vec%0d drain", v));
      check($sformatf("vec%0d idle ready", v), block_ready, 1);
      check($sformatf("vec%0d idle word_out", v), word_out, 0);
    end

    // Burst wrap from offset 14
    accept(32'h38, 1'b1, 32'hA000_0000);
    for (int k = 0; k < 16; k++) begin
      check($sformatf("wrap off k%0d", k), word_offset, (14 + k) % 16);
      check($sformatf("wrap word k%0d", k), word_out, 32'hA000_0000 + ((14 + k) % 16));
      check($sformatf("wrap last k%0d", k), word_last, (k == 15));
      tick();
    end
    check("wrap end valid", word_valid, 0);
    check("wrap end ready", block_ready, 1);

    // Backpressure at offset 5
    accept(32'h00, 1'b1, 32'hA000_0000);
    for (int k = 0; k < 5; k++) begin
      check($sformatf("bp pre word k%0d", k), word_out, 32'hA000_0000 + k);
      tick();
    end
    for (int s = 0; s < 4; s++) begin
      word_ready = (s == 3);
      check($sformatf("bp hold word s%0d", s), word_out, 32'hA000_0005);
      check($sformatf("bp hold off s%0d", s), word_offset, 5);
      check($sformatf("bp hold last s%0d", s), word_last, 0);
      tick();
    end
    for (int k = 6; k < 16; k++) begin
      check($sformatf("bp post word k%0d", k), word_out, 32'hA000_0000 + k);
      check($sformatf("bp post last k%0d", k), word_last, (k == 15));
      tick();
    end
    check("bp end valid", word_valid, 0);

    // Overlap: a new block offered during SEND is held off until the first IDLE cycle
    accept(32'h00, 1'b1, 32'hA000_0000);
    block_in = make_block(32'hB000_0000); address = 32'h20; burst = 1'b0; block_valid = 1'b1;
    for (int k = 0; k < 16; k++) begin
      check($sformatf("ovl ready k%0d", k), block_ready, 0);
      check($sformatf("ovl word k%0d", k), word_out, 32'hA000_0000 + k);
      tick();
    end
    check("ovl bubble valid", word_valid, 0);
    check("ovl bubble ready", block_ready, 1);
    tick();
    block_valid = 1'b0;
    check("ovl new word", word_out, 32'hB000_0008);
    check("ovl new off", word_offset, 8);
    check("ovl new last", word_last, 1);
    drain("ovl drain");

    // Reset mid-burst after 5 words
    accept(32'h00, 1'b1, 32'hA000_0000);
    for (int k = 0; k < 5; k++) tick();
    check("mid word before rst", word_out, 32'hA000_0005);
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    check("mid rst valid", word_valid, 0);
    check("mid rst busy", busy, 0);
    check("mid rst ready", block_ready, 1);
    check("mid rst word_out", word_out, 0);
    check("mid rst last", word_last, 0);
    tick();
    check("mid idle valid", word_valid, 0);
    accept(32'h0C, 1'b1, 32'hA000_0000);
    check("mid fresh word", word_out, 32'hA000_0003);
    check("mid fresh off", word_offset, 3);
    drain("mid drain");

    // Randomized run against a queue of expected words
    q.delete();
    for (int c = 0; c < 3000; c++) begin
      if (q.size() != 0) begin
        check("rnd valid", word_valid, 1);
        check("rnd ready", block_ready, 0);
        check("rnd busy", busy, 1);
        check("rnd word", word_out, q[0].word);
        check("rnd off", word_offset, q[0].off);
        check("rnd last", word_last, q[0].last);
      end else begin
        check("rnd valid", word_valid, 0);
        check("rnd ready", block_ready, 1);
        check("rnd busy", busy, 0);
        check("rnd word", word_out, 0);
      end
      rst_n       = ($urandom_range(0, 199) != 0);
      block_valid = ($urandom_range(0, 2) != 0);
      address     = $urandom;
      burst       = $urandom_range(0, 1);
      for (int i = 0; i < BS; i++) block_in[i*WW +: WW] = $urandom;
      word_ready  = ($urandom_range(0, 3) != 0);
      if (!rst_n) begin
        q.delete();
      end else if (q.size() != 0) begin
        if (word_ready) void'(q.pop_front());
      end else if (block_valid) begin
        start = (address / 4) % BS;
        len   = burst ? BS : 1;
        for (int k = 0; k < len; k++) begin
          o      = (start + k) % BS;
          e.word = block_in[o*WW +: WW];
          e.off  = BL'(o);
          e.last = (k == len - 1);
          q.push_back(e);
        end
      end
      tick();
    end
    rst_n = 1'b1;
    block_valid = 1'b0;
    drain("rnd final drain");

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule
